uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among byte requesters using round-robin selection with lock ownership.
// It owns the launch handshake and flags a transmitter that never reports busy.
module uart_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   lock,
    input  logic [8*N_REQ-1:0] data,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic               err,
    input  logic               err_clr
);
    localparam int idxWidth = $clog2(N_REQ);
    localparam int cntWidth = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE} stateType;

    stateType state, nextState;
    logic ownerValid, ownerValidNext;
    logic [idxWidth-1:0] owner, ownerNext, lastWinner, lastNext, rrIdx, selIdx;
    logic [cntWidth-1:0] cnt, cntNext, cntInc;
    logic [N_REQ-1:0] ackNext, grantNext, selOneHot;
    logic [7:0] dataNext;
    logic startNext, errNext, rrFound, selFound, lockHeld, timeout;

    assign lockHeld = ownerValid && lock[owner];
    assign cntInc = (cnt == cntWidth'(BUSY_TIMEOUT)) ? cnt : cnt + 1'b1;
    assign timeout = cntInc == cntWidth'(BUSY_TIMEOUT);

    // Round-robin search begins one past the previous winner and wraps.
    always_comb begin
        rrFound = 1'b0;
        rrIdx = lastWinner;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!rrFound && req[lastWinner + idxWidth'(k)]) begin
                rrFound = 1'b1;
                rrIdx = lastWinner + idxWidth'(k);
            end
        end
    end

    assign selFound = lockHeld ? req[owner] : rrFound;
    assign selIdx = lockHeld ? owner : rrIdx;
    assign selOneHot = {{(N_REQ-1){1'b0}}, 1'b1} << selIdx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            ack <= '0;
            tx_start <= 1'b0;
            tx_data <= '0;
            err <= 1'b0;
            ownerValid <= 1'b0;
            owner <= '0;
            cnt <= '0;
            lastWinner <= idxWidth'(N_REQ - 1);
        end else begin
            state <= nextState;
            grant <= grantNext;
            ack <= ackNext;
            tx_start <= startNext;
            tx_data <= dataNext;
            err <= errNext;
            ownerValid <= ownerValidNext;
            owner <= ownerNext;
            cnt <= cntNext;
            lastWinner <= lastNext;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      nextState = (!tx_busy && selFound) ? LAUNCH : IDLE;
            LAUNCH:    nextState = WAIT_BUSY;
            WAIT_BUSY: nextState = tx_busy ? WAIT_IDLE : timeout ? IDLE : WAIT_BUSY;
            WAIT_IDLE: nextState = tx_busy ? WAIT_IDLE : IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // A timeout sets err after err_clr is applied, so a simultaneous set wins.
    always_comb begin
        ackNext = '0;
        startNext = 1'b0;
        grantNext = grant;
        dataNext = tx_data;
        ownerValidNext = ownerValid;
        ownerNext = owner;
        cntNext = cnt;
        lastNext = lastWinner;
        errNext = err_clr ? 1'b0 : err;
        case (state)
            IDLE: begin
                if (!tx_busy && !lockHeld) begin
                    ownerValidNext = 1'b0;
                    grantNext = '0;
                end
                if (!tx_busy && selFound) begin
                    ackNext = selOneHot;
                    startNext = 1'b1;
                    grantNext = selOneHot;
                    dataNext = 8'(data >> {selIdx, 3'b000});
                    ownerNext = selIdx;
                    ownerValidNext = 1'b1;
                    cntNext = '0;
                    lastNext = selIdx;
                end
            end
            WAIT_BUSY: begin
                if (!tx_busy) begin
                    cntNext = cntInc;
                    errNext = timeout ? 1'b1 : errNext;
                    grantNext = timeout ? '0 : grant;
                    ownerValidNext = timeout ? 1'b0 : ownerValid;
                end
            end
            WAIT_IDLE: begin
                if (!tx_busy && !lockHeld) begin
                    grantNext = '0;
                    ownerValidNext = 1'b0;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst, txBusy, errClr, txStart, err;
    logic [3:0] req, lock, ack, grant;
    logic [31:0] data;
    logic [7:0] txData;

    int checks = 0;
    int errors = 0;

    logic [3:0] mAck, mGrant;
    logic mStart, mErr;
    logic [7:0] mData;
    bit ownValid, inFlight, sawBusy;
    int own, last, launchAge;

    int busyLeft, minLen, maxLen;
    bit respond, extBusy, prevStart;
    logic [3:0] keep;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .data(data),
        .ack(ack), .grant(grant), .tx_start(txStart), .tx_data(txData),
        .tx_busy(txBusy), .err(err), .err_clr(errClr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model of one clock edge, described per transfer: a launched byte ages each edge,
    // must see busy within TO waiting edges, then completes when busy drops.
    task automatic modelEdge();
        int w;
        bit nErr;
        if (rst) begin
            mAck = 0; mGrant = 0; mStart = 0; mData = 0; mErr = 0;
            ownValid = 0; own = 0; last = 3; inFlight = 0; sawBusy = 0; launchAge = 0;
            return;
        end
        mAck = 0;
        mStart = 0;
        nErr = errClr ? 1'b0 : mErr;
        if (!inFlight) begin
            if (!txBusy) begin
                w = -1;
                if (ownValid && lock[own]) w = req[own] ? own : -1;
                else begin
                    ownValid = 0;
                    mGrant = 0;
                    for (int k = 1; k <= 4; k++)
                        if (w < 0 && req[(last + k) % 4]) w = (last + k) % 4;
                end
                if (w >= 0) begin
                    mAck = 4'(1 << w);
                    mGrant = 4'(1 << w);
                    mStart = 1;
                    mData = data[8*w +: 8];
                    own = w; ownValid = 1; last = w;
                    inFlight = 1; launchAge = 0; sawBusy = 0;
                end
            end
        end else begin
            launchAge++;
            if (launchAge >= 2) begin
                if (sawBusy) begin
                    if (!txBusy) begin
                        inFlight = 0;
                        if (!lock[own]) begin ownValid = 0; mGrant = 0; end
                    end
                end else if (txBusy) sawBusy = 1;
                else if (launchAge == TO + 1) begin
                    inFlight = 0; nErr = 1; ownValid = 0; mGrant = 0;
                end
            end
        end
        mErr = nErr;
    endtask

    task automatic step();
        modelEdge();
        @(posedge clk);
        #1;
        check("ack", ack, mAck);
        check("grant", grant, mGrant);
        check("tx_start", txStart, mStart);
        check("tx_data", txData, mData);
        check("err", err, mErr);
        if (prevStart && respond) busyLeft = $urandom_range(maxLen, minLen);
        else if (busyLeft > 0) busyLeft--;
        txBusy = (busyLeft > 0) || extBusy;
        prevStart = mStart;
    endtask

    task automatic serviceAcks();
        for (int i = 0; i < 4; i++)
            if (mAck[i]) begin
                if (keep[i]) data[8*i +: 8] = 8'($urandom);
                else req[i] = 0;
            end
    endtask

    task automatic untilAck(output int who);
        bit got = 0;
        who = -1;
        for (int n = 0; n < 60 && !got; n++) begin
            step();
            if (ack != 0) begin
                got = 1;
                for (int i = 0; i < 4; i++) if (ack[i]) who = i;
            end
            serviceAcks();
        end
        check("ack_wait", got, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin step(); serviceAcks(); end
    endtask

    task automatic doReset();
        rst = 1; step(); step(); rst = 0;
    endtask

    initial begin
        int who;
        int order[$];
        bit b, launched;
        rst = 1; req = 0; lock = 0; data = 0; errClr = 0; txBusy = 0;
        busyLeft = 0; extBusy = 0; respond = 1; prevStart = 0; keep = 0;
        minLen = 4; maxLen = 4;
        doReset();
        check("rst_grant", grant, 0);
        check("rst_data", txData, 0);

        // single byte
        req = 4'b0001; data[7:0] = 8'h41;
        step();
        check("single_start", txStart, 1);
        check("single_data", txData, 8'h41);
        check("single_ack", ack, 4'b0001);
        check("single_grant", grant, 4'b0001);
        req = 0;
        idle(10);
        check("single_release", grant, 0);

        // round-robin
        doReset();
        minLen = 1; maxLen = 5;
        keep = 4'b1111; req = 4'b1111; data = $urandom;
        order = {};
        for (int n = 0; n < 5; n++) begin untilAck(who); order.push_back(who); end
        foreach (order[i]) check("rr_order", order[i], (i % 4));
        keep = 0; req = 0; idle(12);

        // lock
        doReset();
        keep = 4'b0011; req = 4'b0011; lock = 4'b0010;
        order = {};
        for (int n = 0; n < 4; n++) begin untilAck(who); order.push_back(who); end
        check("lock_first", order[0], 0);
        for (int i = 1; i < 4; i++) check("lock_hold", order[i], 1);
        lock = 0;
        untilAck(who);
        check("lock_release", who, 0);
        keep = 0; req = 0; idle(12);

        // timeout, re-launch, and clear racing a new timeout
        doReset();
        respond = 0;
        req = 4'b0100;
        untilAck(who);
        repeat (15) step();
        check("to_early", err, 0);
        step();
        check("to_set", err, 1);
        check("to_grant", grant, 0);
        req = 4'b0100;
        untilAck(who);
        check("to_relaunch", who, 2);
        repeat (15) step();
        errClr = 1;
        step();
        check("to_clr_race", err, 1);
        step();
        check("err_clr", err, 0);
        errClr = 0;
        respond = 1;

        // reset during WAIT_IDLE
        doReset();
        minLen = 6; maxLen = 6;
        req = 4'b0001;
        untilAck(who);
        repeat (3) step();
        rst = 1;
        step();
        check("mid_rst_grant", grant, 0);
        check("mid_rst_ack", ack, 0);
        check("mid_rst_start", txStart, 0);
        rst = 0;
        req = 4'b0010;
        launched = 0;
        for (int n = 0; n < 20; n++) begin
            b = txBusy;
            step();
            if (txStart) begin launched = 1; check("mid_rst_gate", b, 0); end
            serviceAcks();
        end
        check("mid_rst_launch", launched, 1);
        idle(10);

        // external busy gate
        doReset();
        busyLeft = 0; extBusy = 1; txBusy = 1;
        req = 4'b1000;
        repeat (8) begin step(); check("gate_hold", txStart, 0); end
        extBusy = 0; txBusy = 0;
        step();
        check("gate_launch", txStart, 1);
        check("gate_ack", ack, 4'b1000);
        serviceAcks();
        idle(10);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                respond = ($urandom_range(3, 0) != 0);
                minLen = 1;
                maxLen = $urandom_range(8, 1);
                keep = 4'($urandom);
            end
            rst = ($urandom_range(400, 0) == 0);
            errClr = ($urandom_range(9, 0) == 0);
            if ($urandom_range(30, 0) == 0) extBusy = !extBusy;
            if ($urandom_range(15, 0) == 0) lock = 4'($urandom);
            serviceAcks();
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i] = 1;
                    data[8*i +: 8] = 8'($urandom);
                end else if (req[i] && !mAck[i] && $urandom_range(40, 0) == 0) req[i] = 0;
            end
            txBusy = (busyLeft > 0) || extBusy;
            step();
        end
        rst = 0; errClr = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
